// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared state encoding and counter-width helper for the button debouncer
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } btn_state_e;

  // At least one bit, even for the smallest legal debounce length.
  function automatic int deb_cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// rtl/button_debounce_ch.sv - one button channel: synchroniser, debounce FSM and press counter
module button_debounce_ch
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 48000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pad,
  output logic             level,
  output logic             press,
  output logic             rel,
  output logic [CNT_W-1:0] count
);

  localparam int              DW       = deb_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0]   CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync_q, sync_d;
  btn_state_e       state_q, state_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    sync1_d = ACTIVE_LOW ? ~pad : pad;
    sync_d  = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RELEASED: begin
        if (sync_q) begin
          state_d = DEB_PRESS;
          cnt_d   = DW'(1);
        end
      end
      DEB_PRESS: begin
        if (!sync_q) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!sync_q) begin
          state_d = DEB_RELEASE;
          cnt_d   = DW'(1);
        end
      end
      DEB_RELEASE: begin
        if (sync_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
    // Strobes fire only on the debounced transitions, never on a bounce back.
    level_d = (state_d == PRESSED) || (state_d == DEB_RELEASE);
    press_d = (state_q == DEB_PRESS) && (state_d == PRESSED);
    rel_d   = (state_q == DEB_RELEASE) && (state_d == RELEASED);
    count_d = press_d ? count_q + 1'b1 : count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
      state_q <= RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      count_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      count_q <= count_d;
    end
  end

  assign level = level_q;
  assign press = press_q;
  assign rel   = rel_q;
  assign count = count_q;

endmodule

// File: rtl/button_debounce_in.sv
// rtl/button_debounce_in.sv - NUM_BTN independent debounced pushbutton inputs
module button_debounce_in
  import button_pkg::*;
#(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = 48000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int CNT_W           = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_BTN-1:0]       btn_pad,
  output logic [NUM_BTN-1:0]       btn_level,
  output logic [NUM_BTN-1:0]       btn_press,
  output logic [NUM_BTN-1:0]       btn_release,
  output logic [NUM_BTN*CNT_W-1:0] press_count
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    button_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .pad  (btn_pad[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel  (btn_release[i]),
      .count(press_count[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: doc/button_debounce_in.md
Name: button_debounce_in

Overview:
Input-side counterpart to the LED output path in the GW1N1 generic-flow test designs. It reads NUM_BTN raw pushbutton pads, which are driven by input-only GENERIC_IOB instances placed by BEL in the top level. For each button it synchronises the pad into clk and debounces it with a per-channel state machine. It then outputs a clean level, one-cycle press/release strobes and a wrapping press counter, so top-level designs can count presses or step LED patterns.

Parameters:
NUM_BTN, 2, number of independent button channels
DEBOUNCE_CYCLES, 48000, consecutive stable synchronised samples needed to accept a level change (~2 ms at 24 MHz); legal range 2..2^20
ACTIVE_LOW, 1, 1 = pad reads 0 when pressed (inverted before the synchroniser); 0 = pad reads 1 when pressed
CNT_W, 8, width of each per-channel press counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
btn_pad  input  NUM_BTN  raw asynchronous pad values from the input IOBs
btn_level  output  NUM_BTN  debounced pressed level, 1 = pressed
btn_press  output  NUM_BTN  one-cycle strobe when a channel enters PRESSED
btn_release  output  NUM_BTN  one-cycle strobe when a channel enters RELEASED from DEB_RELEASE
press_count  output  NUM_BTN*CNT_W  per-channel press counter; channel i occupies bits [i*CNT_W +: CNT_W]

Behaviour:
- Polarity: p = ACTIVE_LOW ? ~btn_pad : btn_pad, so p = 1 means pressed.
- Synchroniser: 2 flops per channel (sync1 <= p, s <= sync1). Reset value of both flops is 0 (released).
- Per-channel FSM, states RELEASED, DEB_PRESS, PRESSED, DEB_RELEASE. Debounce counter width is clog2(DEBOUNCE_CYCLES).
  - RELEASED: if s = 1, go to DEB_PRESS with cnt <= 1.
  - DEB_PRESS: if s = 0, go to RELEASED with cnt <= 0 (bounce restarts the debounce). Else if cnt == DEBOUNCE_CYCLES-1, go to PRESSED. Else cnt++.
  - PRESSED: if s = 0, go to DEB_RELEASE with cnt <= 1.
  - DEB_RELEASE: if s = 1, go to PRESSED with cnt <= 0. Else if cnt == DEBOUNCE_CYCLES-1, go to RELEASED. Else cnt++.
- Outputs (all registered):
  - btn_level = 1 in PRESSED and DEB_RELEASE; 0 in RELEASED and DEB_PRESS.
  - btn_press is high for exactly the first cycle the state is PRESSED after DEB_PRESS. It does not pulse on DEB_RELEASE -> PRESSED.
  - btn_release is high for exactly the first cycle of RELEASED after DEB_RELEASE. It does not pulse on DEB_PRESS -> RELEASED.
  - press_count increments in the same cycle btn_press asserts. It wraps from 2^CNT_W-1 to 0 with no saturation.
- Latency: with the pad held pressed, btn_level and btn_press rise after rising edge N+DEBOUNCE_CYCLES+1, where N is the edge that first samples the pressed pad into sync1. Release latency is identical.
- Channels are fully independent. Simultaneous presses on several channels give simultaneous strobes and increments.
- Reset: asserted for any number of cycles, including mid-debounce. All FSMs go to RELEASED, counters and press_count go to 0, synchronisers go to 0, all outputs go to 0.
  - A button held across reset deassertion is reported as a fresh press after the full latency: one btn_press, count becomes 1.
- Reset has priority over all other conditions.
- No combinational path from btn_pad to any output.

Decomposition:
- Shared package button_pkg:
  - state enum (RELEASED=2'd0, DEB_PRESS=2'd1, PRESSED=2'd2, DEB_RELEASE=2'd3)
  - clog2-based counter-width helper
- Natural sub-module button_debounce_ch: one channel containing the synchroniser, FSM, debounce counter and press counter. The top instantiates it NUM_BTN times via generate.

Test Plan:
- DEBOUNCE_CYCLES=4, ACTIVE_LOW=1. btn_pad[0] driven 1->0 at edge 10 and held -> btn_level[0] rises after edge 15; btn_press[0] high for exactly one cycle; press_count[0] = 1; channel 1 unchanged.
- Bounce on press: pad low 2 cycles, high 1 cycle, low held -> debounce restarts; btn_level rises 5 edges after the final low is first sampled; exactly one btn_press.
- Release bounce: from PRESSED, pad high 2 cycles then low again -> btn_level stays 1; no btn_release, no btn_press. Later a clean release -> one btn_release, btn_level = 0.
- Wrap: CNT_W=8, 256 clean presses on channel 1 -> press_count[1] reads 255 then 0; 256 btn_press pulses counted.
- Reset mid-debounce: assert rst for 3 cycles during DEB_PRESS with pad held -> all outputs 0 during reset; after release, full latency before btn_press; press_count = 1.
- Simultaneous: both pads pressed on the same edge -> both btn_press pulses in the same cycle; both counters = 1. ACTIVE_LOW=0 variant repeats the first scenario with pad 0->1.
